// File: rtl/tile_dispatcher_if.sv
// ============================================================================
// Module      : tile_dispatcher_if
// Description : Triangle input stream and tile-job output stream of the
//               tile dispatcher. Vertices are packed {z, y, x}, each signed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tile_dispatcher_if #(
    parameter int FX_TOTAL_BITS = 16,
    parameter int COLOR_BITS    = 8,
    parameter int TILE_X_BITS   = 6,
    parameter int TILE_Y_BITS   = 5
);
    localparam int c_vtx_bits  = 3 * FX_TOTAL_BITS;
    localparam int c_meta_bits = COLOR_BITS + TILE_X_BITS + TILE_Y_BITS;

    logic                   up_vld;
    logic                   up_rdy;
    logic [c_vtx_bits-1:0]  up_v0;
    logic [c_vtx_bits-1:0]  up_v1;
    logic [c_vtx_bits-1:0]  up_v2;
    logic [COLOR_BITS-1:0]  up_colors;

    logic                   tp_vld;
    logic                   tp_rdy;
    logic [c_vtx_bits-1:0]  tp_v0;
    logic [c_vtx_bits-1:0]  tp_v1;
    logic [c_vtx_bits-1:0]  tp_v2;
    logic [c_meta_bits-1:0] tp_metadata;

    // Dispatcher side: sinks triangles, sources tile jobs
    modport master (
        input  up_vld, up_v0, up_v1, up_v2, up_colors, tp_rdy,
        output up_rdy, tp_vld, tp_v0, tp_v1, tp_v2, tp_metadata
    );

    // Environment side: sources triangles, sinks tile jobs
    modport slave (
        output up_vld, up_v0, up_v1, up_v2, up_colors, tp_rdy,
        input  up_rdy, tp_vld, tp_v0, tp_v1, tp_v2, tp_metadata
    );
endinterface

`default_nettype wire

// File: rtl/tile_dispatcher.sv
// ============================================================================
// Module      : tile_dispatcher
// Description : Computes the clamped tile bounding box of one triangle and
//               issues one tile_processor job per covered tile, row-major.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_dispatcher #(
    parameter int TILE_PX_LOG2  = 4,
    parameter int TILE_COLS     = 40,
    parameter int TILE_ROWS     = 30,
    parameter int FX_FRAC_BITS  = 4,
    parameter int FX_TOTAL_BITS = 16,
    parameter int COLOR_BITS    = 8,
    parameter int TILE_X_BITS   = 6,
    parameter int TILE_Y_BITS   = 5
) (
    input  wire logic           clk,
    input  wire logic           rst,
    tile_dispatcher_if.master   bus,
    output logic                busy,
    output logic                tri_done,
    output logic [15:0]         tiles_issued
);

    localparam int c_vtx_bits = 3 * FX_TOTAL_BITS;
    localparam int c_shift    = FX_FRAC_BITS + TILE_PX_LOG2;
    localparam logic signed [FX_TOTAL_BITS-1:0] c_cols    = FX_TOTAL_BITS'(TILE_COLS);
    localparam logic signed [FX_TOTAL_BITS-1:0] c_rows    = FX_TOTAL_BITS'(TILE_ROWS);
    localparam logic signed [FX_TOTAL_BITS-1:0] c_col_max = FX_TOTAL_BITS'(TILE_COLS - 1);
    localparam logic signed [FX_TOTAL_BITS-1:0] c_row_max = FX_TOTAL_BITS'(TILE_ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BBOX  = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_vtx_bits-1:0]   r_v0;
    logic [c_vtx_bits-1:0]   r_v1;
    logic [c_vtx_bits-1:0]   r_v2;
    logic [COLOR_BITS-1:0]   r_colors;
    logic [TILE_X_BITS-1:0]  r_xmin;
    logic [TILE_X_BITS-1:0]  r_xmax;
    logic [TILE_Y_BITS-1:0]  r_ymax;
    logic [TILE_X_BITS-1:0]  r_cur_x;
    logic [TILE_Y_BITS-1:0]  r_cur_y;
    logic [15:0]             r_tiles_issued;
    logic                    w_done;

    // Arithmetic shift floors negative coordinates toward -inf
    function automatic logic signed [FX_TOTAL_BITS-1:0] tile_of(
        input logic [FX_TOTAL_BITS-1:0] c
    );
        return $signed(c) >>> c_shift;
    endfunction

    function automatic logic signed [FX_TOTAL_BITS-1:0] min3(
        input logic signed [FX_TOTAL_BITS-1:0] a,
        input logic signed [FX_TOTAL_BITS-1:0] b,
        input logic signed [FX_TOTAL_BITS-1:0] c
    );
        logic signed [FX_TOTAL_BITS-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [FX_TOTAL_BITS-1:0] max3(
        input logic signed [FX_TOTAL_BITS-1:0] a,
        input logic signed [FX_TOTAL_BITS-1:0] b,
        input logic signed [FX_TOTAL_BITS-1:0] c
    );
        logic signed [FX_TOTAL_BITS-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    logic signed [FX_TOTAL_BITS-1:0] w_tx0, w_tx1, w_tx2, w_ty0, w_ty1, w_ty2;
    logic signed [FX_TOTAL_BITS-1:0] w_xmin, w_xmax, w_ymin, w_ymax;
    logic signed [FX_TOTAL_BITS-1:0] w_xlo, w_xhi, w_ylo, w_yhi;
    logic                            w_cull;

    assign w_tx0 = tile_of(r_v0[FX_TOTAL_BITS-1:0]);
    assign w_tx1 = tile_of(r_v1[FX_TOTAL_BITS-1:0]);
    assign w_tx2 = tile_of(r_v2[FX_TOTAL_BITS-1:0]);
    assign w_ty0 = tile_of(r_v0[2*FX_TOTAL_BITS-1:FX_TOTAL_BITS]);
    assign w_ty1 = tile_of(r_v1[2*FX_TOTAL_BITS-1:FX_TOTAL_BITS]);
    assign w_ty2 = tile_of(r_v2[2*FX_TOTAL_BITS-1:FX_TOTAL_BITS]);

    assign w_xmin = min3(w_tx0, w_tx1, w_tx2);
    assign w_xmax = max3(w_tx0, w_tx1, w_tx2);
    assign w_ymin = min3(w_ty0, w_ty1, w_ty2);
    assign w_ymax = max3(w_ty0, w_ty1, w_ty2);

    assign w_cull = w_xmax[FX_TOTAL_BITS-1] || w_ymax[FX_TOTAL_BITS-1] ||
                    (w_xmin >= c_cols) || (w_ymin >= c_rows);

    // Clamped bounds always fit the tile index fields
    assign w_xlo = w_xmin[FX_TOTAL_BITS-1] ? '0 : w_xmin;
    assign w_ylo = w_ymin[FX_TOTAL_BITS-1] ? '0 : w_ymin;
    assign w_xhi = (w_xmax > c_col_max) ? c_col_max : w_xmax;
    assign w_yhi = (w_ymax > c_row_max) ? c_row_max : w_ymax;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.up_vld) begin
                    w_state_nxt = ST_BBOX;
                end
            end
            ST_BBOX: begin
                if (w_cull) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.tp_rdy && !(r_cur_x < r_xmax) && !(r_cur_y < r_ymax)) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v0           <= '0;
            r_v1           <= '0;
            r_v2           <= '0;
            r_colors       <= '0;
            r_xmin         <= '0;
            r_xmax         <= '0;
            r_ymax         <= '0;
            r_cur_x        <= '0;
            r_cur_y        <= '0;
            r_tiles_issued <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.up_vld) begin
                        r_v0           <= bus.up_v0;
                        r_v1           <= bus.up_v1;
                        r_v2           <= bus.up_v2;
                        r_colors       <= bus.up_colors;
                        r_tiles_issued <= '0;
                    end
                end
                ST_BBOX: begin
                    if (!w_cull) begin
                        r_xmin  <= TILE_X_BITS'(w_xlo);
                        r_xmax  <= TILE_X_BITS'(w_xhi);
                        r_ymax  <= TILE_Y_BITS'(w_yhi);
                        r_cur_x <= TILE_X_BITS'(w_xlo);
                        r_cur_y <= TILE_Y_BITS'(w_ylo);
                    end
                end
                ST_ISSUE: begin
                    if (bus.tp_rdy) begin
                        r_tiles_issued <= r_tiles_issued + 16'd1;
                        if (r_cur_x < r_xmax) begin
                            r_cur_x <= r_cur_x + 1'b1;
                        end else if (r_cur_y < r_ymax) begin
                            r_cur_x <= r_xmin;
                            r_cur_y <= r_cur_y + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.up_rdy      = (r_state == ST_IDLE);
    assign bus.tp_vld      = (r_state == ST_ISSUE);
    assign bus.tp_v0       = r_v0;
    assign bus.tp_v1       = r_v1;
    assign bus.tp_v2       = r_v2;
    assign bus.tp_metadata = {r_colors, r_cur_x, r_cur_y};
    assign busy            = (r_state != ST_IDLE);
    // A synchronous reset in the final handshake cycle must not report completion
    assign tri_done        = w_done && !rst;
    assign tiles_issued    = r_tiles_issued;

endmodule

`default_nettype wire
